pc_gen: RTL and testbench

//  Parametrised program-counter generator for the fetch stage; successor to the fixed +4 PC register.

---
 rtl/pc_gen_pkg.sv | 21 ++
 rtl/pc_redirect_buf.sv | 33 +++
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator: enable levels,
// instruction address width, FSM state encodings and default vectors.
package pc_gen_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;

  localparam int INST_ADDR_W = 32;

  localparam logic [INST_ADDR_W-1:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] DEFAULT_EXC_VEC   = 32'h0000_0020;
  localparam int                     DEFAULT_STEP      = 4;

  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry pending-target register for a branch that arrives while the
// pipeline is stalled; clear beats capture, and capture beats consume.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = INST_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              clear,
  input  logic              consume,
  input  logic [ADDR_W-1:0] capture_tgt,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  // A capture while already valid simply overwrites: the youngest branch wins.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (capture) begin
      valid  <= 1'b1;
      target <= capture_tgt;
    end else if (consume) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator with stall, branch and flush redirects.
// Optional target alignment check: define PC_ALIGN_CHK_EN.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int                ADDR_W    = INST_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = DEFAULT_RESET_VEC,
  parameter int                STEP      = DEFAULT_STEP,
  parameter logic [ADDR_W-1:0] EXC_VEC   = DEFAULT_EXC_VEC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_tgt_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic              ce_o,
  output logic              misalign_o
);

  pc_state_t         state;
  logic              active;
  logic              pend_valid;
  logic [ADDR_W-1:0] pend_tgt;
  logic              buf_capture;
  logic              buf_clear;
  logic              buf_consume;
  logic              take_branch;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              tgt_bad;
  logic [ADDR_W-1:0] load_pc;

`ifdef PC_ALIGN_CHK_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STEP - 1);
`endif

  pc_redirect_buf #(
    .ADDR_W(ADDR_W)
  ) u_redirect_buf (
    .clk        (clk),
    .rst        (rst),
    .capture    (buf_capture),
    .clear      (buf_clear),
    .consume    (buf_consume),
    .capture_tgt(branch_tgt_i),
    .valid      (pend_valid),
    .target     (pend_tgt)
  );

  // Redirect priority: flush, then a buffered branch, then a live branch.
  always_comb begin
    active       = (state != S_RST);
    buf_clear    = active && flush_i;
    buf_consume  = active && !flush_i && pend_valid && !stall_i;
    take_branch  = active && !flush_i && !pend_valid && branch_i && !stall_i;
    buf_capture  = active && !flush_i && branch_i && stall_i;
    redirect     = active && (flush_i || buf_consume || take_branch);
    redirect_tgt = branch_tgt_i;
    if (flush_i) begin
      redirect_tgt = flush_pc_i;
    end else if (pend_valid) begin
      redirect_tgt = pend_tgt;
    end
`ifdef PC_ALIGN_CHK_EN
    tgt_bad = redirect && ((redirect_tgt & ALIGN_MASK) != '0);
`else
    tgt_bad = 1'b0;
`endif
    load_pc = tgt_bad ? EXC_VEC : redirect_tgt;
  end

  // The first enabled cycle fetches RESET_VEC, so leaving S_RST does not increment.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state      <= S_RST;
      pc_o       <= RESET_VEC;
      ce_o       <= CHIP_DISABLE;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        S_RST: begin
          state <= S_RUN;
          ce_o  <= CHIP_ENABLE;
          pc_o  <= RESET_VEC;
        end
        S_RUN, S_HOLD: begin
          ce_o <= CHIP_ENABLE;
          if (redirect) begin
            pc_o       <= load_pc;
            misalign_o <= tgt_bad;
            state      <= S_RUN;
          end else if (buf_capture) begin
            state <= S_HOLD;
          end else if (!stall_i) begin
            pc_o <= pc_o + ADDR_W'(STEP);
          end
        end
        default: begin
          state <= S_RST;
          ce_o  <= CHIP_DISABLE;
          pc_o  <= RESET_VEC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed self-checking bench for pc_gen with hand-computed expectations.
// Build with PC_ALIGN_CHK_EN defined to exercise the alignment check.
module tb_pc_gen;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_tgt_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] pc_o;
  logic        ce_o;
  logic        misalign_o;

  int passed;
  int total;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall_i),
    .branch_i    (branch_i),
    .branch_tgt_i(branch_tgt_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .pc_o        (pc_o),
    .ce_o        (ce_o),
    .misalign_o  (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp_pc, input logic exp_ce);
    check({tag, ".pc"}, pc_o, exp_pc);
    check({tag, ".ce"}, {31'd0, ce_o}, {31'd0, exp_ce});
  endtask

  initial begin
    passed       = 0;
    total        = 0;
    rst          = 1'b1;
    stall_i      = 1'b0;
    branch_i     = 1'b0;
    branch_tgt_i = '0;
    flush_i      = 1'b0;
    flush_pc_i   = '0;

    // 1: reset for three cycles, then sequential fetch from RESET_VEC
    for (int i = 0; i < 3; i++) begin
      tick();
      check_pc("rst_hold", 32'h0, 1'b0);
    end
    check("rst_misalign", {31'd0, misalign_o}, 32'h0);
    rst = 1'b0;
    tick(); check_pc("first_fetch", 32'h0, 1'b1);
    tick(); check_pc("seq_4", 32'h4, 1'b1);
    tick(); check_pc("seq_8", 32'h8, 1'b1);
    tick(); check_pc("seq_c", 32'hC, 1'b1);

    // 2: unstalled branch
    branch_i = 1'b1; branch_tgt_i = 32'h100;
    tick(); check_pc("branch_100", 32'h100, 1'b1);
    branch_i = 1'b0;
    tick(); check_pc("branch_104", 32'h104, 1'b1);

    // 3: branch during a three-cycle stall is buffered
    stall_i = 1'b1; branch_i = 1'b1; branch_tgt_i = 32'h200;
    tick(); check_pc("stall_c1", 32'h104, 1'b1);
    branch_i = 1'b0;
    tick(); check_pc("stall_c2", 32'h104, 1'b1);
    tick(); check_pc("stall_c3", 32'h104, 1'b1);
    stall_i = 1'b0;
    tick(); check_pc("pend_200", 32'h200, 1'b1);
    tick(); check_pc("pend_204", 32'h204, 1'b1);

    // 4: flush + branch + stall in the same cycle: flush wins, branch dropped
    flush_i = 1'b1; flush_pc_i = 32'h80;
    branch_i = 1'b1; branch_tgt_i = 32'h300; stall_i = 1'b1;
    tick(); check_pc("flush_80", 32'h80, 1'b1);
    flush_i = 1'b0; branch_i = 1'b0;
    tick(); check_pc("flush_hold", 32'h80, 1'b1);
    stall_i = 1'b0;
    tick(); check_pc("flush_84", 32'h84, 1'b1);
    tick(); check_pc("flush_88", 32'h88, 1'b1);

    // flush while holding a pending branch clears it
    stall_i = 1'b1; branch_i = 1'b1; branch_tgt_i = 32'h400;
    tick(); check_pc("hold_88", 32'h88, 1'b1);
    branch_i = 1'b0; flush_i = 1'b1; flush_pc_i = 32'h40;
    tick(); check_pc("hold_flush_40", 32'h40, 1'b1);
    flush_i = 1'b0; stall_i = 1'b0;
    tick(); check_pc("hold_flush_44", 32'h44, 1'b1);

    // youngest pending branch wins
    stall_i = 1'b1; branch_i = 1'b1; branch_tgt_i = 32'h500;
    tick(); check_pc("young_hold1", 32'h44, 1'b1);
    branch_tgt_i = 32'h600;
    tick(); check_pc("young_hold2", 32'h44, 1'b1);
    branch_i = 1'b0; stall_i = 1'b0;
    tick(); check_pc("young_600", 32'h600, 1'b1);

    // 5: wrap from max address to zero
    branch_i = 1'b1; branch_tgt_i = 32'hFFFF_FFFC;
    tick(); check_pc("wrap_max", 32'hFFFF_FFFC, 1'b1);
    branch_i = 1'b0;
    tick(); check_pc("wrap_0", 32'h0, 1'b1);
    tick(); check_pc("wrap_4", 32'h4, 1'b1);

    // reset while holding a pending branch drops it
    stall_i = 1'b1; branch_i = 1'b1; branch_tgt_i = 32'h700;
    tick(); check_pc("rst_hold_4", 32'h4, 1'b1);
    stall_i = 1'b0; branch_i = 1'b0; rst = 1'b1;
    tick(); check_pc("midrst", 32'h0, 1'b0);
    rst = 1'b0;
    tick(); check_pc("midrst_first", 32'h0, 1'b1);
    tick(); check_pc("midrst_seq", 32'h4, 1'b1);

    // 6: misaligned branch target
    branch_i = 1'b1; branch_tgt_i = 32'h102;
    tick();
`ifdef PC_ALIGN_CHK_EN
    check_pc("misalign_exc", 32'h20, 1'b1);
    check("misalign_pulse", {31'd0, misalign_o}, 32'h1);
    branch_i = 1'b0;
    tick();
    check_pc("misalign_next", 32'h24, 1'b1);
    check("misalign_clear", {31'd0, misalign_o}, 32'h0);
`else
    check_pc("unaligned_load", 32'h102, 1'b1);
    check("misalign_tied", {31'd0, misalign_o}, 32'h0);
    branch_i = 1'b0;
    tick();
    check_pc("unaligned_next", 32'h106, 1'b1);
    check("misalign_tied2", {31'd0, misalign_o}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
